arr_chk: RTL and testbench

Parametrised multi-channel compare checker for the example testbench: N independent channels each compare an expected and an actual WIDTH-bit value when their valid is high. Mismatches are counted per cycle and in total, the first failure is captured, and a finish request is raised once a programmable error threshold is reached. It sits beside the duv, clocked from the sim_ctrl clock, and replaces the single-pair always-on compare with a pipelined, counted, haltable checker.

---
 rtl/arr_chk_if.sv | 40 ++++
 rtl/arr_chk.sv | 139 +++++++++++++
 tb/tb_arr_chk.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/arr_chk_if.sv
// Compare-checker bus: stimulus/control toward the checker, results back.
interface arr_chk_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       arr_chk_en_ip;
  logic [CHANNELS-1:0]       arr_chk_vld_ip;
  logic [CHANNELS*WIDTH-1:0] arr_chk_exp_ip;
  logic [CHANNELS*WIDTH-1:0] arr_chk_act_ip;
  logic                      arr_chk_clr_ip;
  logic [CNT_W-1:0]          arr_chk_thresh_ip;
  logic [CHANNELS-1:0]       arr_chk_err_op;
  logic [CNT_W-1:0]          arr_chk_total_op;
  logic [CNT_W-1:0]          arr_chk_cmp_op;
  logic                      arr_chk_first_vld_op;
  logic [CH_W-1:0]           arr_chk_first_ch_op;
  logic [31:0]               arr_chk_first_cyc_op;
  logic [WIDTH-1:0]          arr_chk_first_exp_op;
  logic [WIDTH-1:0]          arr_chk_first_act_op;
  logic                      arr_chk_finish_op;

  modport master (
    output arr_chk_en_ip, arr_chk_vld_ip, arr_chk_exp_ip, arr_chk_act_ip,
           arr_chk_clr_ip, arr_chk_thresh_ip,
    input  arr_chk_err_op, arr_chk_total_op, arr_chk_cmp_op,
           arr_chk_first_vld_op, arr_chk_first_ch_op, arr_chk_first_cyc_op,
           arr_chk_first_exp_op, arr_chk_first_act_op, arr_chk_finish_op
  );

  modport slave (
    input  arr_chk_en_ip, arr_chk_vld_ip, arr_chk_exp_ip, arr_chk_act_ip,
           arr_chk_clr_ip, arr_chk_thresh_ip,
    output arr_chk_err_op, arr_chk_total_op, arr_chk_cmp_op,
           arr_chk_first_vld_op, arr_chk_first_ch_op, arr_chk_first_cyc_op,
           arr_chk_first_exp_op, arr_chk_first_act_op, arr_chk_finish_op
  );
endinterface

// File: rtl/arr_chk.sv
// Multi-channel pipelined compare checker: per-channel mismatch detection,
// saturating compare/mismatch counters, first-failure capture and a
// threshold-driven halt with a level finish request.
module arr_chk #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic     arr_chk_clk_ip,
  input  logic     arr_chk_rst_ip,
  arr_chk_if.slave bus
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t              r_state;
  logic [31:0]         r_cyc;
  logic [CHANNELS-1:0] r_s1_act, r_s1_mis;
  logic [WIDTH-1:0]    r_s1_exp, r_s1_actv;
  logic [CH_W-1:0]     r_s1_ch;
  logic [31:0]         r_s1_cyc;
  logic [CNT_W-1:0]    r_cmp, r_total;
  logic [CHANNELS-1:0] r_err;
  logic                r_first_vld;
  logic [CH_W-1:0]     r_first_ch;
  logic [31:0]         r_first_cyc;
  logic [WIDTH-1:0]    r_first_exp, r_first_act;
  logic                r_finish;

  logic [CHANNELS-1:0] w_active, w_mis;
  logic [WIDTH-1:0]    w_low_exp, w_low_act;
  logic [CH_W-1:0]     w_low_ch;
  logic [7:0]          w_cmp_inc, w_tot_inc;
  logic [SUM_W-1:0]    w_cmp_sum, w_tot_sum;
  logic [CNT_W-1:0]    w_cmp_next, w_tot_next;
  logic                w_halt_go;

  // Per-channel activity/mismatch; HALT makes every channel inactive.
  // Descending scan leaves the lowest mismatching channel in w_low_*.
  always_comb begin
    w_active  = '0;
    w_mis     = '0;
    w_low_ch  = '0;
    w_low_exp = '0;
    w_low_act = '0;
    if (r_state == ST_RUN) w_active = bus.arr_chk_en_ip & bus.arr_chk_vld_ip;
    for (int unsigned c = 0; c < CHANNELS; c++)
      w_mis[c] = w_active[c] &
                 (bus.arr_chk_exp_ip[c*WIDTH +: WIDTH] != bus.arr_chk_act_ip[c*WIDTH +: WIDTH]);
    for (int unsigned c = CHANNELS; c > 0; c--) begin
      if (w_mis[c-1]) begin
        w_low_ch  = CH_W'(c-1);
        w_low_exp = bus.arr_chk_exp_ip[(c-1)*WIDTH +: WIDTH];
        w_low_act = bus.arr_chk_act_ip[(c-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Stage-2 increments, saturating sums and the halt decision.
  always_comb begin
    w_cmp_inc = '0;
    w_tot_inc = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_cmp_inc = w_cmp_inc + 8'(r_s1_act[c]);
      w_tot_inc = w_tot_inc + 8'(r_s1_mis[c]);
    end
    w_cmp_sum  = SUM_W'(r_cmp) + SUM_W'(w_cmp_inc);
    w_tot_sum  = SUM_W'(r_total) + SUM_W'(w_tot_inc);
    w_cmp_next = (w_cmp_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_cmp_sum[CNT_W-1:0];
    w_tot_next = (w_tot_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_tot_sum[CNT_W-1:0];
    w_halt_go  = (r_state == ST_RUN) && (bus.arr_chk_thresh_ip != '0) &&
                 (w_tot_next >= bus.arr_chk_thresh_ip);
  end

  // Free-running cycle counter; only reset touches it.
  always_ff @(posedge arr_chk_clk_ip) begin
    if (arr_chk_rst_ip) r_cyc <= '0;
    else                r_cyc <= r_cyc + 32'd1;
  end

  // Pipeline, counters, capture and RUN/HALT control.
  always_ff @(posedge arr_chk_clk_ip) begin
    if (arr_chk_rst_ip || bus.arr_chk_clr_ip) begin
      r_state     <= ST_RUN;
      r_s1_act    <= '0;
      r_s1_mis    <= '0;
      r_s1_exp    <= '0;
      r_s1_actv   <= '0;
      r_s1_ch     <= '0;
      r_s1_cyc    <= '0;
      r_cmp       <= '0;
      r_total     <= '0;
      r_err       <= '0;
      r_first_vld <= 1'b0;
      r_first_ch  <= '0;
      r_first_cyc <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_finish    <= 1'b0;
    end else begin
      // The entry sampled on the halting edge is dropped, not carried into HALT.
      r_s1_act  <= w_halt_go ? '0 : w_active;
      r_s1_mis  <= w_halt_go ? '0 : w_mis;
      r_s1_exp  <= w_low_exp;
      r_s1_actv <= w_low_act;
      r_s1_ch   <= w_low_ch;
      r_s1_cyc  <= r_cyc;
      if (r_state == ST_RUN) begin
        r_cmp   <= w_cmp_next;
        r_total <= w_tot_next;
        r_err   <= r_err | r_s1_mis;
        if (!r_first_vld && (r_s1_mis != '0)) begin
          r_first_vld <= 1'b1;
          r_first_ch  <= r_s1_ch;
          r_first_cyc <= r_s1_cyc;
          r_first_exp <= r_s1_exp;
          r_first_act <= r_s1_actv;
        end
        if (w_halt_go) begin
          r_state  <= ST_HALT;
          r_finish <= 1'b1;
        end
      end
    end
  end

  assign bus.arr_chk_err_op       = r_err;
  assign bus.arr_chk_total_op     = r_total;
  assign bus.arr_chk_cmp_op       = r_cmp;
  assign bus.arr_chk_first_vld_op = r_first_vld;
  assign bus.arr_chk_first_ch_op  = r_first_ch;
  assign bus.arr_chk_first_cyc_op = r_first_cyc;
  assign bus.arr_chk_first_exp_op = r_first_exp;
  assign bus.arr_chk_first_act_op = r_first_act;
  assign bus.arr_chk_finish_op    = r_finish;
endmodule

// File: tb/tb_arr_chk.sv
// Directed bench for arr_chk: a default instance (4x8, 16-bit counters) and a
// 4-bit-counter instance for saturation.
module tb_arr_chk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  arr_chk_if #(.CHANNELS(4), .WIDTH(8), .CNT_W(16)) bus ();
  arr_chk_if #(.CHANNELS(4), .WIDTH(8), .CNT_W(4))  bus4 ();

  arr_chk #(.CHANNELS(4), .WIDTH(8), .CNT_W(16)) u_dut (
    .arr_chk_clk_ip(clk), .arr_chk_rst_ip(rst), .bus(bus));
  arr_chk #(.CHANNELS(4), .WIDTH(8), .CNT_W(4)) u_dut4 (
    .arr_chk_clk_ip(clk), .arr_chk_rst_ip(rst), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] vld,
                       input logic [31:0] ex, input logic [31:0] ac);
    bus.arr_chk_en_ip  = en;
    bus.arr_chk_vld_ip = vld;
    bus.arr_chk_exp_ip = ex;
    bus.arr_chk_act_ip = ac;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'hF, 4'h0, '0, '0);
    bus.arr_chk_clr_ip     = 1'b0;
    bus.arr_chk_thresh_ip  = '0;
    bus4.arr_chk_en_ip     = 4'hF;
    bus4.arr_chk_vld_ip    = 4'h0;
    bus4.arr_chk_exp_ip    = '0;
    bus4.arr_chk_act_ip    = '0;
    bus4.arr_chk_clr_ip    = 1'b0;
    bus4.arr_chk_thresh_ip = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0) begin n_fail++; $display("FAIL rst_total got %0d want 0", bus.arr_chk_total_op); end
    n_cmp++; if (bus.arr_chk_cmp_op !== 16'd0) begin n_fail++; $display("FAIL rst_cmp got %0d want 0", bus.arr_chk_cmp_op); end
    n_cmp++; if (bus.arr_chk_err_op !== 4'h0) begin n_fail++; $display("FAIL rst_err got %b want 0000", bus.arr_chk_err_op); end
    n_cmp++; if (bus.arr_chk_first_vld_op !== 1'b0 || bus.arr_chk_first_cyc_op !== 32'd0) begin n_fail++; $display("FAIL rst_first got vld=%b cyc=%0d want 0/0", bus.arr_chk_first_vld_op, bus.arr_chk_first_cyc_op); end
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL rst_finish got %b want 0", bus.arr_chk_finish_op); end
  endtask

  task automatic test_match();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] v;
      v = 32'h01010101 * (i + 3);
      drive(4'hF, 4'hF, v, v);
      tick();
    end
    drive(4'hF, 4'h0, '0, '0);
    tick();
    tick();
    n_cmp++; if (bus.arr_chk_cmp_op !== 16'd40) begin n_fail++; $display("FAIL match_cmp got %0d want 40", bus.arr_chk_cmp_op); end
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0) begin n_fail++; $display("FAIL match_total got %0d want 0", bus.arr_chk_total_op); end
    n_cmp++; if (bus.arr_chk_err_op !== 4'h0 || bus.arr_chk_first_vld_op !== 1'b0) begin n_fail++; $display("FAIL match_err got err=%b fv=%b want 0000/0", bus.arr_chk_err_op, bus.arr_chk_first_vld_op); end
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL match_finish got %b want 0", bus.arr_chk_finish_op); end
  endtask

  task automatic test_first();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 4'hF, 32'h015A2211, 32'h015A2211);
      tick();
    end
    drive(4'hF, 4'hF, 32'h015A2211, 32'h005B2211);
    tick();
    drive(4'hF, 4'h0, '0, '0);
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0) begin n_fail++; $display("FAIL first_latency got %0d want 0", bus.arr_chk_total_op); end
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd2) begin n_fail++; $display("FAIL first_total got %0d want 2", bus.arr_chk_total_op); end
    n_cmp++; if (bus.arr_chk_err_op !== 4'b1100) begin n_fail++; $display("FAIL first_err got %b want 1100", bus.arr_chk_err_op); end
    n_cmp++; if (bus.arr_chk_first_ch_op !== 2'd2 || bus.arr_chk_first_vld_op !== 1'b1) begin n_fail++; $display("FAIL first_ch got ch=%0d vld=%b want 2/1", bus.arr_chk_first_ch_op, bus.arr_chk_first_vld_op); end
    n_cmp++; if (bus.arr_chk_first_cyc_op !== 32'd5) begin n_fail++; $display("FAIL first_cyc got %0d want 5", bus.arr_chk_first_cyc_op); end
    n_cmp++; if (bus.arr_chk_first_exp_op !== 8'h5A || bus.arr_chk_first_act_op !== 8'h5B) begin n_fail++; $display("FAIL first_vals got %h/%h want 5a/5b", bus.arr_chk_first_exp_op, bus.arr_chk_first_act_op); end
    n_cmp++; if (bus.arr_chk_cmp_op !== 16'd24) begin n_fail++; $display("FAIL first_cmp got %0d want 24", bus.arr_chk_cmp_op); end
  endtask

  task automatic test_thresh();
    do_reset();
    bus.arr_chk_thresh_ip = 16'd3;
    drive(4'hF, 4'h1, 32'h00000042, 32'h00000043);
    tick();
    tick();
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd2 || bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL thr_pre got total=%0d fin=%b want 2/0", bus.arr_chk_total_op, bus.arr_chk_finish_op); end
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd3 || bus.arr_chk_finish_op !== 1'b1) begin n_fail++; $display("FAIL thr_hit got total=%0d fin=%b want 3/1", bus.arr_chk_total_op, bus.arr_chk_finish_op); end
    tick();
    tick();
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd3 || bus.arr_chk_cmp_op !== 16'd3) begin n_fail++; $display("FAIL thr_frozen got total=%0d cmp=%0d want 3/3", bus.arr_chk_total_op, bus.arr_chk_cmp_op); end
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b1) begin n_fail++; $display("FAIL thr_hold got %b want 1", bus.arr_chk_finish_op); end
  endtask

  task automatic test_clr();
    bus.arr_chk_clr_ip = 1'b1;
    tick();
    bus.arr_chk_clr_ip = 1'b0;
    drive(4'hF, 4'h0, '0, '0);
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b0 || bus.arr_chk_total_op !== 16'd0 || bus.arr_chk_cmp_op !== 16'd0) begin n_fail++; $display("FAIL clr_cnt got fin=%b total=%0d cmp=%0d want 0/0/0", bus.arr_chk_finish_op, bus.arr_chk_total_op, bus.arr_chk_cmp_op); end
    n_cmp++; if (bus.arr_chk_err_op !== 4'h0 || bus.arr_chk_first_vld_op !== 1'b0) begin n_fail++; $display("FAIL clr_err got err=%b fv=%b want 0000/0", bus.arr_chk_err_op, bus.arr_chk_first_vld_op); end
    tick();
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0) begin n_fail++; $display("FAIL clr_discard got %0d want 0", bus.arr_chk_total_op); end
    drive(4'hF, 4'h2, 32'h00001000, 32'h00001100);
    tick();
    drive(4'hF, 4'h0, '0, '0);
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd1 || bus.arr_chk_err_op !== 4'b0010) begin n_fail++; $display("FAIL clr_new got total=%0d err=%b want 1/0010", bus.arr_chk_total_op, bus.arr_chk_err_op); end
    n_cmp++; if (bus.arr_chk_first_ch_op !== 2'd1 || bus.arr_chk_first_exp_op !== 8'h10 || bus.arr_chk_first_act_op !== 8'h11) begin n_fail++; $display("FAIL clr_first got ch=%0d %h/%h want 1 10/11", bus.arr_chk_first_ch_op, bus.arr_chk_first_exp_op, bus.arr_chk_first_act_op); end
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL clr_fin got %b want 0", bus.arr_chk_finish_op); end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 4'hF, 32'h33221100, 32'h34221100);
      tick();
    end
    drive(4'hF, 4'h0, '0, '0);
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0 || bus.arr_chk_err_op !== 4'h0) begin n_fail++; $display("FAIL en_total got total=%0d err=%b want 0/0000", bus.arr_chk_total_op, bus.arr_chk_err_op); end
    n_cmp++; if (bus.arr_chk_cmp_op !== 16'd9) begin n_fail++; $display("FAIL en_cmp got %0d want 9", bus.arr_chk_cmp_op); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus4.arr_chk_exp_ip = 32'h000000AA;
    bus4.arr_chk_act_ip = 32'h00000055;
    bus4.arr_chk_vld_ip = 4'h1;
    for (int i = 0; i < 20; i++) tick();
    bus4.arr_chk_vld_ip = 4'h0;
    tick();
    n_cmp++; if (bus4.arr_chk_total_op !== 4'd15 || bus4.arr_chk_cmp_op !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got total=%0d cmp=%0d want 15/15", bus4.arr_chk_total_op, bus4.arr_chk_cmp_op); end
    n_cmp++; if (bus4.arr_chk_finish_op !== 1'b0 || bus4.arr_chk_err_op !== 4'b0001) begin n_fail++; $display("FAIL sat_fin got fin=%b err=%b want 0/0001", bus4.arr_chk_finish_op, bus4.arr_chk_err_op); end
  endtask

  task automatic test_lower_thresh();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 4'h8, 32'h07000000, 32'h70000000);
      tick();
    end
    drive(4'hF, 4'h0, '0, '0);
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd4 || bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL low_pre got total=%0d fin=%b want 4/0", bus.arr_chk_total_op, bus.arr_chk_finish_op); end
    bus.arr_chk_thresh_ip = 16'd2;
    tick();
    n_cmp++; if (bus.arr_chk_finish_op !== 1'b1 || bus.arr_chk_total_op !== 16'd4) begin n_fail++; $display("FAIL low_halt got fin=%b total=%0d want 1/4", bus.arr_chk_finish_op, bus.arr_chk_total_op); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(4'hF, 4'h2, 32'h0000AB00, 32'h0000BA00);
    tick();
    rst = 1'b1;
    drive(4'hF, 4'h0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.arr_chk_total_op !== 16'd0 || bus.arr_chk_cmp_op !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt got total=%0d cmp=%0d want 0/0", bus.arr_chk_total_op, bus.arr_chk_cmp_op); end
    n_cmp++; if (bus.arr_chk_err_op !== 4'h0 || bus.arr_chk_first_vld_op !== 1'b0 || bus.arr_chk_finish_op !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got err=%b fv=%b fin=%b want 0000/0/0", bus.arr_chk_err_op, bus.arr_chk_first_vld_op, bus.arr_chk_finish_op); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_first();
    test_thresh();
    test_clr();
    test_enable();
    test_saturate();
    test_lower_thresh();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
